// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch definitions: text-segment bounds, default reset PC and the
// buffer entry layout {fault, pc, inst}.
// Optional feature macro: FETCH_RANGE_CHECK_EN (consumes TEXT_BEGIN/TEXT_END).
`ifndef INSTRUCTION_FETCH_UNIT_DEFINES
`define INSTRUCTION_FETCH_UNIT_DEFINES
`define TEXT_BEGIN 32'h0040_0000
`define TEXT_END   32'h0FFF_FFFF
`endif

package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;

  // Entry layout: fault at bit 64, pc at [63:32], inst at [31:0]
  localparam int unsigned ENTRY_W          = 65;
  localparam int unsigned ENTRY_INST_LSB   = 0;
  localparam int unsigned ENTRY_PC_LSB     = 32;
  localparam int unsigned ENTRY_FAULT_BIT  = 64;

  typedef struct packed {
    logic            fault;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Small synchronous fetch buffer with flush; push and pop may coincide when full.
module fetch_fifo
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointers and occupancy; flush wins over any push/pop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are only observed through a non-zero count
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-word reads to a 1-cycle
// text memory, buffers returned words and hands them to decode.
// Optional feature macro: FETCH_RANGE_CHECK_EN (fault on PC outside text segment).
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_read_en,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(FIFO_DEPTH);

  logic [XLEN-1:0]    pc;
  logic [XLEN-1:0]    req_pc;
  logic               inflight;
  logic               pop;
  logic               push;
  logic               issue;
  logic               fault_push;
  logic [CW-1:0]      count;
  logic [OW-1:0]      occ;
  logic [ENTRY_W-1:0] head;
  fetch_entry_t       push_entry;

  assign pop = inst_valid & inst_ready;
  // Slots already committed: buffered + in flight, less the entry leaving now
  assign occ = OW'(count) + OW'(inflight) - OW'(pop);

`ifdef FETCH_RANGE_CHECK_EN
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  logic halted;
  logic in_range;

  assign in_range   = (pc >= `TEXT_BEGIN) && (pc <= `TEXT_END);
  assign issue      = reset_n && !redirect_valid && !halted && in_range && (occ < DEPTH_O);
  // Fault entry waits for the in-flight word so the two never push together
  assign fault_push = !redirect_valid && !halted && !in_range && !inflight &&
                      ((count - CW'(pop)) < DEPTH_C);

  // Halt after the single fault entry until the next redirect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            halted <= 1'b0;
    else if (redirect_valid) halted <= 1'b0;
    else if (fault_push)     halted <= 1'b1;
  end
`else
  assign issue      = reset_n && !redirect_valid && (occ < DEPTH_O);
  assign fault_push = 1'b0;
`endif

  assign push = !redirect_valid && (inflight || fault_push);

  // Build the entry pushed this cycle: returned word or a fault marker
  always_comb begin
    push_entry = '0;
    if (fault_push) begin
      push_entry.fault = 1'b1;
      push_entry.pc    = pc;
    end else begin
      push_entry.pc    = req_pc;
      push_entry.inst  = mem_data;
    end
  end

  // PC, request PC and in-flight tracking; redirect drops any pending return
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + XLEN'(4);
        req_pc <= pc;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head),
    .count     (count)
  );

  assign mem_read_en = issue;
  assign mem_address = pc;
  assign inst_valid  = (count != '0);
  assign inst_data   = inst_valid ? head[ENTRY_INST_LSB +: XLEN] : '0;
  assign inst_pc     = inst_valid ? head[ENTRY_PC_LSB +: XLEN]   : '0;
  assign fetch_fault = inst_valid & head[ENTRY_FAULT_BIT];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboarded bench for instruction_fetch_unit: the expected instruction
// stream is derived from the architectural rule "sequential PCs from the last
// reset/redirect target", data = pc ^ A5A5A5A5.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] MAGIC  = 32'hA5A5_A5A5;
  localparam int unsigned STREAM_LEN = 512;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        mem_read_en;
  logic [31:0] mem_address;
  logic [31:0] mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [31:0] tgt;
  logic [31:0] mem_q;

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_read_en    (mem_read_en),
    .mem_address    (mem_address),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Text memory: word is valid the cycle after the read, garbage otherwise
  always @(posedge clk) mem_q <= mem_read_en ? (mem_address ^ MAGIC) : $urandom;
  assign mem_data = mem_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream restarts at a new PC; anything queued before is flushed
  task automatic start_stream(input logic [31:0] start);
    exp_t n;
    exp_q.delete();
    for (int i = 0; i < STREAM_LEN; i++) begin
      n.pc    = start + 32'(i) * 32'd4;
      n.data  = n.pc ^ MAGIC;
      n.fault = 1'b0;
      exp_q.push_back(n);
    end
  endtask

  // Monitor: every accepted beat must match the front of the expected stream
  always @(negedge clk) begin
    if (reset_n && mem_read_en) check("addr_align", {30'd0, mem_address[1:0]}, 32'd0);
    if (reset_n && inst_valid && inst_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got pc %h with no expected entry", inst_pc);
      end else begin
        e = exp_q.pop_front();
        check("beat_pc",    inst_pc,     e.pc);
        check("beat_data",  inst_data,   e.data);
        check("beat_fault", fetch_fault, e.fault);
      end
    end
  end

  // Called just after a rising edge: release reset and check cycle-0/2 latency
  task automatic release_reset();
    start_stream(RST_PC);
    inst_ready = 1'b1;
    reset_n    = 1'b1;
    @(negedge clk);
    check("c0_read_en", mem_read_en, 1);
    check("c0_addr",    mem_address, RST_PC);
    check("c0_valid",   inst_valid,  0);
    @(negedge clk);
    check("c1_valid",   inst_valid,  0);
    @(negedge clk);
    check("c2_valid",   inst_valid,  1);
    check("c2_pc",      inst_pc,     RST_PC);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_read_en"}, mem_read_en, 0);
    check({tag, "_valid"},   inst_valid,  0);
    check({tag, "_data"},    inst_data,   0);
    check({tag, "_pc"},      inst_pc,     0);
    check({tag, "_fault"},   fetch_fault, 0);
  endtask

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");

    // Streaming from reset with decode always ready: no gaps
    release_reset();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("stream_no_gap", inst_valid, 1);
    end

    // Backpressure: buffer fills to depth, fetch stops, head holds
    @(posedge clk); #1 inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    check("bp_valid",   inst_valid,   1);
    check("bp_read_en", mem_read_en,  0);
    check("bp_count",   32'(dut.count), 2);
    check("bp_head_pc", inst_pc,      exp_q[0].pc);
    @(posedge clk); #1 inst_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Redirect with a word in flight and a pop offered in the same cycle
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0103;
    start_stream(32'h0040_0100);
    @(negedge clk);
    check("redir_no_issue", mem_read_en, 0);
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_r1_valid", inst_valid, 0);
    check("redir_r1_addr",  mem_address, 32'h0040_0100);
    @(negedge clk);
    check("redir_r2_valid", inst_valid, 0);
    @(negedge clk);
    check("redir_r3_valid", inst_valid, 1);
    check("redir_r3_pc",    inst_pc,    32'h0040_0100);
    repeat (4) @(negedge clk);

`ifdef FETCH_RANGE_CHECK_EN
    // Out-of-range target: one fault entry, then no reads until redirect
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = `TEXT_END + 32'd1;
    exp_q.delete();
    exp_q.push_back('{(`TEXT_END + 32'd1) & ~32'd3, 32'd0, 1'b1});
    @(posedge clk); #1 redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("halt_no_read", mem_read_en, 0);
    end
    check("fault_consumed", 32'(exp_q.size()), 0);
    check("halt_empty",     inst_valid, 0);
`else
    // PC wraps modulo 2^32
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    start_stream(32'hFFFF_FFF8);
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("wrap_progress", 32'(exp_q.size() <= STREAM_LEN - 4), 1);
`endif

    // Restart from a known target before random traffic
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = RST_PC;
    start_stream(RST_PC);

    // Random ready and redirects
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      inst_ready = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) begin
        tgt            = RST_PC + (32'($urandom_range(255)) << 2) + 32'($urandom_range(3));
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        start_stream({tgt[31:2], 2'b00});
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    repeat (8) @(negedge clk);

    // Asynchronous reset between edges mid-stream, then restart
    @(posedge clk); #3 reset_n = 1'b0;
    #1 check_outputs_zero("async_rst");
    @(posedge clk); #1 release_reset();
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
